dbus_ctrl: RTL and testbench
============================

# dbus_ctrl

Data-bus controller between the mem stage and a byte-wide external data RAM. It takes the mem stage's word-oriented request (address, byte-lane select, write data, write enable), runs one RAM handshake per enabled byte lane, and assembles read data. It then returns the assembled word to the mem stage as its load data. While a request is in flight it raises a stall request to the pipeline controller.

## Interface
- ADDR_W, 17, RAM byte-address width
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- mem_ce_i  in  1  request valid from mem stage
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address from mem stage
- mem_sel_i  in  4  lane select; bit 3 = lane 0 = data[31:24] (big-endian)
- mem_data_i  in  32  store data
- stall_i  in  1  pipeline held by another stage this cycle
- mem_data_o  out  32  assembled load data to mem stage
- stallreq_o  out  1  stall request to pipeline controller
- misalign_o  out  1  misaligned word access flag (see Configuration)
- ram_req_o  out  1  RAM byte request
- ram_we_o  out  1  RAM write strobe, valid with ram_req_o
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wdata_o  out  8  RAM write byte
- ram_rdata_i  in  8  RAM read byte, valid when ram_ack_i = 1
- ram_ack_i  in  1  RAM completes current byte at this rising edge

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE: if mem_ce_i = 1, latch addr, we, sel and wdata at the clock edge, clear mem_data_o to 0 and load a remaining-lane mask with sel.
  - If sel = 0000: go to DONE.
  - Otherwise: go to ACCESS.
- ACCESS: the current lane k is the lowest-numbered set lane in the mask (sel bit 3 first).
  - Drive ram_req_o = 1, ram_addr_o = {addr[ADDR_W-1:2], k}, ram_we_o = latched we.
  - Drive ram_wdata_o = wdata[31-8k : 24-8k].
  - Hold all of these stable until ram_ack_i = 1.
  - On ack: clear bit k of the mask. For a load, write ram_rdata_i into mem_data_o[31-8k : 24-8k]. Unselected lanes stay 0; no sign extension, which is the mem stage's job.
  - When the mask becomes empty, go to DONE.
- DONE: ram_req_o = 0 and mem_data_o holds its value.
  - If stall_i = 1, stay in DONE.
  - Otherwise go to IDLE. The request still present this cycle is not re-issued.
- mem_data_o keeps its value in IDLE until the next request is latched.
- stallreq_o = (IDLE and mem_ce_i) or ACCESS. It is 0 in DONE and 0 while rst = 1.
- Only bits [ADDR_W-1:0] of the address are used. Upper bits are ignored and there is no range check.

## Timing
- Reset value of every output is 0: mem_data_o, stallreq_o, misalign_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o. The FSM resets to IDLE.
- Reset mid-access takes effect immediately, asynchronously: ram_req_o drops with no wait for ack, and the partial load data is discarded.
- Stall cycles = 1 (IDLE latch) + the sum over lanes of the cycles each lane waits for ack. This is followed by one DONE cycle in which the mem stage samples mem_data_o.
- With ram_ack_i tied to 1:
  - LB/SB stall for 2 cycles.
  - LW/SW stall for 5 cycles.
  - sel = 0000 stalls for 1 cycle.
- Back-to-back requests: after DONE → IDLE, a new mem_ce_i starts the next access. There is a minimum of one non-stall cycle (DONE) between accesses.
- ram_ack_i is ignored when ram_req_o = 0.

## Configuration
- DBUS_ALIGN_CHECK_EN defined:
  - A request with sel = 1111 and addr[1:0] ≠ 00 performs no RAM cycles and goes IDLE → DONE.
  - mem_data_o = 0 and misalign_o = 1 during that DONE cycle only. Stores write nothing.
- DBUS_ALIGN_CHECK_EN undefined:
  - addr[1:0] is ignored for word accesses and lanes use {addr[ADDR_W-1:2], k}.
  - misalign_o is tied to 0.

## Test plan
- Load word, ack tied high, addr 0x100, RAM bytes 0x11,0x22,0x33,0x44 → ram_addr 0x100..0x103 in order, stallreq_o high 5 cycles, then mem_data_o = 0x11223344 in DONE.
- Store byte, sel 0010, addr 0x0206, data 0xABABABAB → exactly one RAM write at 0x0206 with byte 0xAB; stallreq_o high 2 cycles.
- Load byte with ack delayed 3 cycles, sel 0100, RAM byte 0x80 → request held stable 4 cycles, stallreq_o high 5 cycles, mem_data_o = 0x00800000.
- stall_i = 1 for 2 cycles in DONE after LW → stays in DONE, no new RAM request, mem_data_o constant; returns to IDLE when stall_i drops.
- rst asserted during the 3rd lane of LW → ram_req_o and all outputs 0 immediately. After release with mem_ce_i = 1, the access restarts from lane 0.
- With DBUS_ALIGN_CHECK_EN: SW at addr 0x102 → no ram_req_o, stallreq_o high 1 cycle, misalign_o = 1 for 1 cycle.
- Without DBUS_ALIGN_CHECK_EN: SW at addr 0x102 → writes 0x100..0x103 and misalign_o stays 0.

Source files
------------

// File: rtl/dbus_if.sv
// ---------------------------------------------------------------------------
// dbus_if : signal bundle between the mem stage / data RAM and dbus_ctrl.
//
// Handshake (RAM side): while ram_req_o = 1 the controller holds ram_we_o,
// ram_addr_o and ram_wdata_o stable. The byte transfer completes at the first
// rising edge where ram_ack_i = 1; ram_rdata_i is sampled at that same edge.
// ram_ack_i has no meaning while ram_req_o = 0.
// Mem-stage side: mem_ce_i presents a word request. stallreq_o = 1 tells the
// pipeline to hold. mem_data_o is valid in the first cycle where stallreq_o
// drops after a load.
//
// Modports:
//   slave  : the controller (dbus_ctrl)
//   master : the environment driving it (mem stage + byte RAM)
// ---------------------------------------------------------------------------
interface dbus_if #(
  parameter int ADDR_W = 17
);
  // mem stage -> controller
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_i;
  logic              stall_i;
  // controller -> mem stage / pipeline control
  logic [31:0]       mem_data_o;
  logic              stallreq_o;
  logic              misalign_o;
  // controller <-> byte RAM
  logic              ram_req_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_wdata_o;
  logic [7:0]        ram_rdata_i;
  logic              ram_ack_i;

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, stall_i,
    input  ram_rdata_i, ram_ack_i,
    output mem_data_o, stallreq_o, misalign_o,
    output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, stall_i,
    output ram_rdata_i, ram_ack_i,
    input  mem_data_o, stallreq_o, misalign_o,
    input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/dbus_ctrl.sv
// ---------------------------------------------------------------------------
// dbus_ctrl : data-bus controller between the mem stage and a byte-wide RAM.
//
// A word request (addr, 4-bit big-endian lane select, write data, we) is split
// into one RAM byte handshake per selected lane, lane 0 (= sel[3] =
// data[31:24]) first. Load bytes are assembled into mem_data_o; unselected
// lanes read as 0. The pipeline is stalled while the request is in flight,
// followed by one DONE cycle in which the mem stage samples mem_data_o.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : dbus_if.slave (mem-stage request/response + RAM handshake)
//   dbg_state : current FSM state (0 = IDLE, 1 = ACCESS, 2 = DONE)
//
// Optional feature macro: DBUS_ALIGN_CHECK_EN. When defined, a word access
// (sel = 1111) with addr[1:0] != 0 performs no RAM cycles and raises
// misalign_o in its DONE cycle. When undefined, misalign_o is 0 and addr[1:0]
// is ignored for word accesses.
// ---------------------------------------------------------------------------
module dbus_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic       clk,
  input  logic       rst,
  dbus_if.slave      bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-3:0] addr_hi_q;  // word address; the lane supplies bits [1:0]
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q;     // lanes still to transfer, bit 3 = lane 0
  logic [31:0]       data_q;

  logic [1:0]        lane;
  logic [3:0]        lane_bit;
  logic [3:0]        mask_next;
  logic [7:0]        lane_wbyte;
  logic              latch;
  logic              ack_ok;
  logic              misalign_req;

  // Address bits outside the RAM window (and the byte offset, which the lanes
  // replace) are deliberately ignored.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr_i[31:ADDR_W], bus.mem_addr_i[1:0]};

  assign latch  = (state == IDLE) && bus.mem_ce_i;
  assign ack_ok = (state == ACCESS) && bus.ram_ack_i;

`ifdef DBUS_ALIGN_CHECK_EN
  logic misalign_q;

  assign misalign_req = (bus.mem_sel_i == 4'hF) && (bus.mem_addr_i[1:0] != 2'b00);

  // Set on the rejected request, held through its DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (latch) begin
      misalign_q <= misalign_req;
    end else if (state == DONE && !bus.stall_i) begin
      misalign_q <= 1'b0;
    end
  end

  assign bus.misalign_o = misalign_q && (state == DONE);
`else
  assign misalign_req   = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  // Current lane: lowest-numbered lane still pending (mask bit 3 first).
  always_comb begin
    lane = 2'd0;
    casez (mask_q)
      4'b1???: lane = 2'd0;
      4'b01??: lane = 2'd1;
      4'b001?: lane = 2'd2;
      4'b0001: lane = 2'd3;
      default: lane = 2'd0;
    endcase
  end

  assign lane_bit  = 4'b1000 >> lane;
  assign mask_next = mask_q & ~lane_bit;

  always_comb begin
    lane_wbyte = 8'h00;
    case (lane)
      2'd0: lane_wbyte = wdata_q[31:24];
      2'd1: lane_wbyte = wdata_q[23:16];
      2'd2: lane_wbyte = wdata_q[15:8];
      2'd3: lane_wbyte = wdata_q[7:0];
      default: lane_wbyte = 8'h00;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.mem_ce_i) begin
          if (bus.mem_sel_i == 4'b0000 || misalign_req) begin
            state_next = DONE;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.ram_ack_i && mask_next == 4'b0000) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // A request still held on mem_ce_i here has already been served.
        if (!bus.stall_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.ram_req_o   = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = 8'h00;
    if (state == ACCESS) begin
      bus.ram_req_o   = 1'b1;
      bus.ram_we_o    = we_q;
      bus.ram_addr_o  = {addr_hi_q, lane};
      bus.ram_wdata_o = lane_wbyte;
    end
  end

  // Gated by rst so the pipeline sees no stall while the block is in reset,
  // even if mem_ce_i is already high.
  assign bus.stallreq_o = !rst && (latch || (state == ACCESS));
  assign bus.mem_data_o = data_q;
  assign dbg_state      = state;

  // ---------------- request / data registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hi_q <= '0;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      mask_q    <= 4'b0000;
      data_q    <= 32'h0;
    end else if (latch) begin
      addr_hi_q <= bus.mem_addr_i[ADDR_W-1:2];
      we_q      <= bus.mem_we_i;
      wdata_q   <= bus.mem_data_i;
      mask_q    <= misalign_req ? 4'b0000 : bus.mem_sel_i;
      data_q    <= 32'h0;
    end else if (ack_ok) begin
      mask_q <= mask_next;
      if (!we_q) begin
        case (lane)
          2'd0: data_q[31:24] <= bus.ram_rdata_i;
          2'd1: data_q[23:16] <= bus.ram_rdata_i;
          2'd2: data_q[15:8]  <= bus.ram_rdata_i;
          2'd3: data_q[7:0]   <= bus.ram_rdata_i;
          default: data_q <= data_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dbus_ctrl : self-checking bench for dbus_ctrl.
// A byte-RAM responder answers requests after a programmable ack delay. Each
// request pushes its expected RAM byte transactions into exp_q; the responder
// pops and compares them as the handshakes complete. Stall length, load data,
// DONE behaviour and reset behaviour are checked per request.
// ---------------------------------------------------------------------------
module tb_dbus_ctrl;
  localparam int ADDR_W = 17;
  localparam int TXN_W  = 1 + ADDR_W + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dbus_if #(.ADDR_W(ADDR_W)) bus();
  logic [1:0] dbg_state;

  dbus_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [TXN_W-1:0] exp_q[$];
  logic [7:0]       ram [0:(1<<ADDR_W)-1];
  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  logic             held_valid = 1'b0;
  logic [TXN_W-1:0] held_txn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- RAM responder ----------------
  always @(negedge clk) begin
    logic [TXN_W-1:0] txn;
    txn = {bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o};
    if (bus.ram_req_o && !rst) begin
      if (held_valid) check("req_stable", 32'(txn), 32'(held_txn));
      if (wait_cnt >= ack_delay) begin
        bus.ram_ack_i   = 1'b1;
        bus.ram_rdata_i = ram[bus.ram_addr_o];
        wait_cnt   = 0;
        held_valid = 1'b0;
        if (exp_q.size() == 0) check("unexpected_ram_txn", 32'(txn), 32'hFFFF_FFFF);
        else                   check("ram_txn", 32'(txn), 32'(exp_q.pop_front()));
      end else begin
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = 8'h00;
        wait_cnt++;
        held_valid = 1'b1;
        held_txn   = txn;
      end
    end else begin
      bus.ram_ack_i   = 1'b0;
      bus.ram_rdata_i = 8'h00;
      wait_cnt   = 0;
      held_valid = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input int delay, input int hold,
                         input string tag);
    logic [31:0] exp_data;
    logic [31:0] d_done;
    logic        mis;
    int          exp_stall;
    int          n;
    exp_data  = 32'h0;
    mis       = 1'b0;
`ifdef DBUS_ALIGN_CHECK_EN
    mis = (sel == 4'hF) && (addr[1:0] != 2'b00);
`endif
    exp_stall = 1;
    if (!mis) begin
      for (int k = 0; k < 4; k++) begin
        if (sel[3-k]) begin
          logic [ADDR_W-1:0] a;
          logic [1:0]        kk;
          kk = k[1:0];
          a  = {addr[ADDR_W-1:2], kk};
          exp_q.push_back({we, a, wdata[31-8*k -: 8]});
          exp_stall += delay + 1;
          if (we) ram[a] = wdata[31-8*k -: 8];
          else    exp_data[31-8*k -: 8] = ram[a];
        end
      end
    end

    ack_delay = delay;
    @(negedge clk);
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = we;
    bus.mem_addr_i = addr;
    bus.mem_sel_i  = sel;
    bus.mem_data_i = wdata;
    #1;
    n = 0;
    while (bus.stallreq_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, n, exp_stall);
    check({tag, "_done_state"}, 32'(dbg_state), 32'd2);
    check({tag, "_done_data"}, bus.mem_data_o, exp_data);
    check({tag, "_done_misalign"}, 32'(bus.misalign_o), 32'(mis));
    check({tag, "_done_no_req"}, 32'(bus.ram_req_o), 32'd0);
    d_done = exp_data;

    // Hold DONE with stall_i while the request is still presented.
    bus.stall_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check({tag, "_hold_state"}, 32'(dbg_state), 32'd2);
      check({tag, "_hold_no_req"}, 32'(bus.ram_req_o), 32'd0);
      check({tag, "_hold_data"}, bus.mem_data_o, d_done);
      check({tag, "_hold_stallreq"}, 32'(bus.stallreq_o), 32'd0);
    end
    bus.stall_i = 1'b0;
    @(negedge clk);
    bus.mem_ce_i = 1'b0;
    #1;
    check({tag, "_idle_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_idle_data"}, bus.mem_data_o, d_done);
    check({tag, "_idle_misalign"}, 32'(bus.misalign_o), 32'd0);
    check({tag, "_exp_q_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, 32'(bus.ram_req_o), 32'd0);
    check({tag, "_we"}, 32'(bus.ram_we_o), 32'd0);
    check({tag, "_addr"}, 32'(bus.ram_addr_o), 32'd0);
    check({tag, "_wdata"}, 32'(bus.ram_wdata_o), 32'd0);
    check({tag, "_data"}, bus.mem_data_o, 32'd0);
    check({tag, "_stallreq"}, 32'(bus.stallreq_o), 32'd0);
    check({tag, "_misalign"}, 32'(bus.misalign_o), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'(i * 7 + 3);
    ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
    ram[17'h301] = 8'h80;

    bus.mem_ce_i = 1'b1;  // request already present while in reset
    bus.mem_we_i = 1'b0;  bus.mem_addr_i = 32'h0; bus.mem_sel_i = 4'hF;
    bus.mem_data_i = 32'h0; bus.stall_i = 1'b0;
    bus.ram_ack_i = 1'b0; bus.ram_rdata_i = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    bus.mem_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_req(1'b0, 32'h0000_0100, 4'b1111, 32'h0,         0, 0, "lw");
    run_req(1'b1, 32'h0000_0206, 4'b0010, 32'hABAB_ABAB, 0, 0, "sb");
    run_req(1'b0, 32'h0000_0301, 4'b0100, 32'h0,         3, 0, "lb_delay");
    run_req(1'b0, 32'h0000_0100, 4'b1111, 32'h0,         0, 2, "lw_stall");
    run_req(1'b0, 32'h0000_0400, 4'b0000, 32'h0,         0, 1, "sel0");
    run_req(1'b1, 32'h0000_0102, 4'b1111, 32'hDEAD_BEEF, 0, 0, "sw_misalign");
    run_req(1'b0, 32'hFFFE_0100, 4'b1001, 32'h0,         1, 0, "upper_addr");

    // Reset during the third lane of a load word.
    @(negedge clk);
    ack_delay = 0;
    exp_q.push_back({1'b0, 17'h300, 8'h00});
    exp_q.push_back({1'b0, 17'h301, 8'h00});
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h300;
    bus.mem_sel_i = 4'hF; bus.mem_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    check("rst_mid_lanes_done", exp_q.size(), 0);
    @(negedge clk);
    #1;
    check("rst_mid_req_low", 32'(bus.ram_req_o), 32'd0);
    bus.mem_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_req(1'b0, 32'h0000_0300, 4'b1111, 32'h0, 0, 0, "lw_after_rst");

    // Randomised requests.
    for (int i = 0; i < 8; i++) begin
      run_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h1_FFFF)),
              4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2),
              $urandom_range(0, 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
